// File: rtl/input_bcd2bin.sv
// input_bcd2bin: converts the four entered digits to a DATA_W-bit binary word
// with one multiply-by-10-and-add per cycle and a CPU read/new-data handshake.
module input_bcd2bin #(
    parameter bit SIGNED_X1 = 1'b0,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x1,
    input  logic [3:0]        x2,
    input  logic [3:0]        x3,
    input  logic [3:0]        x4,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              new_flag,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    state_t            state_q;
    logic [12:0]       snap_q;
    logic [DATA_W-1:0] acc_q;
    logic [1:0]        idx_q;
    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              new_flag_q;
    logic              busy_q;
    logic [12:0]       live_d;
    logic [3:0]        dig_d;
    logic [DATA_W-1:0] acc_d;

    function automatic logic [3:0] clamp(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    always_comb begin
        live_d = {x1, clamp(x2), clamp(x3), clamp(x4)};
        dig_d  = (idx_q == 2'd0) ? (SIGNED_X1 ? 4'd0 : {3'd0, snap_q[12]}) :
                 (idx_q == 2'd1) ? snap_q[11:8] :
                 (idx_q == 2'd2) ? snap_q[7:4] : snap_q[3:0];
        acc_d  = (acc_q << 3) + (acc_q << 1) + DATA_W'(dig_d);
    end

    // The DONE branch follows the read so its new_flag set wins a same-cycle read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            result_q   <= '0;
            rd_data_q  <= '0;
            new_flag_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            if (rd_en) begin
                rd_data_q  <= result_q;
                new_flag_q <= 1'b0;
            end
            case (state_q)
                IDLE: if (live_d != snap_q) begin
                    snap_q  <= live_d;
                    acc_q   <= '0;
                    idx_q   <= '0;
                    state_q <= CONV;
                    busy_q  <= 1'b1;
                end
                CONV: begin
                    acc_q   <= acc_d;
                    idx_q   <= idx_q + 2'd1;
                    state_q <= (idx_q == 2'd3) ? DONE : CONV;
                end
                DONE: begin
                    result_q   <= (SIGNED_X1 && snap_q[12]) ? -acc_q : acc_q;
                    new_flag_q <= 1'b1;
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_data  = rd_data_q;
    assign new_flag = new_flag_q;
    assign busy     = busy_q;
endmodule

// File: tb/tb_input_bcd2bin.sv
// tb_input_bcd2bin: drives an unsigned and a signed instance with shared inputs
// and checks each read against a queue of expected conversions.
module tb_input_bcd2bin;
    typedef struct {
        logic [31:0] u;
        logic [31:0] s;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        x1 = 1'b0;
    logic [3:0]  x2 = '0, x3 = '0, x4 = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data0, rd_data1;
    logic        new_flag0, new_flag1, busy0, busy1;
    exp_t        q[$];
    exp_t        e;
    int          pass = 0;
    int          total = 0;
    int          cnt;
    bit          idle_ok;

    always #5 clk = ~clk;

    input_bcd2bin #(.SIGNED_X1(1'b0), .DATA_W(32)) u_uns (
        .clk(clk), .rst(rst), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .rd_en(rd_en),
        .rd_data(rd_data0), .new_flag(new_flag0), .busy(busy0)
    );

    input_bcd2bin #(.SIGNED_X1(1'b1), .DATA_W(32)) u_sgn (
        .clk(clk), .rst(rst), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .rd_en(rd_en),
        .rd_data(rd_data1), .new_flag(new_flag1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic logic [3:0] cl(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    function automatic exp_t model(input logic a, input logic [3:0] b, c, d);
        exp_t r;
        int   mag;
        mag = int'(cl(b)) * 100 + int'(cl(c)) * 10 + int'(cl(d));
        r.u = 32'(int'(a) * 1000 + mag);
        r.s = a ? 32'(-mag) : 32'(mag);
        return r;
    endfunction

    task automatic set_in(input logic a, input logic [3:0] b, c, d);
        x1 = a; x2 = b; x3 = c; x4 = d;
        q.push_back(model(a, b, c, d));
    endtask

    // Counts busy cycles seen on negedges, bounded so a stuck busy cannot hang.
    task automatic run_conv(input string tag);
        @(negedge clk);
        cnt = 0;
        while ((busy0 || busy1) && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(cnt), 32'd5);
        chk({tag, "_flag_u"}, {31'd0, new_flag0}, 32'd1);
        chk({tag, "_flag_s"}, {31'd0, new_flag1}, 32'd1);
    endtask

    task automatic do_read(input string tag);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        e = q.pop_front();
        chk({tag, "_rd_u"}, rd_data0, e.u);
        chk({tag, "_rd_s"}, rd_data1, e.s);
        chk({tag, "_clr_u"}, {31'd0, new_flag0}, 32'd0);
        chk({tag, "_clr_s"}, {31'd0, new_flag1}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy0 || busy1) idle_ok = 1'b0;
        end
        chk("idle_no_busy", {31'd0, idle_ok}, 32'd1);
        chk("rst_rd_u", rd_data0, 32'd0);
        chk("rst_rd_s", rd_data1, 32'd0);
        chk("rst_flag", {30'd0, new_flag0, new_flag1}, 32'd0);

        set_in(1'b1, 4'd2, 4'd3, 4'd4);
        run_conv("c1234");
        do_read("c1234");
        chk("c1234_hex", rd_data0, 32'h0000_04D2);

        set_in(1'b1, 4'd1, 4'd2, 4'd5);
        run_conv("c1125");
        do_read("c1125");
        chk("neg125_hex", rd_data1, 32'hFFFF_FF83);

        set_in(1'b1, 4'd0, 4'd0, 4'd0);
        run_conv("negzero");
        do_read("negzero");

        set_in(1'b0, 4'd0, 4'd0, 4'd0);
        run_conv("zero");
        do_read("zero");

        set_in(1'b0, 4'd0, 4'd0, 4'd7);
        @(negedge clk);
        @(negedge clk);
        set_in(1'b0, 4'd3, 4'd0, 4'd7);
        cnt = 0;
        while ((busy0 || busy1) && cnt < 20) begin
            cnt++;
            @(negedge clk);
        end
        chk("mid_first_done", {30'd0, busy0, new_flag0}, 32'd1);
        @(negedge clk);
        chk("mid_restart", {30'd0, busy0, busy1}, 32'd3);
        chk("mid_flag_held", {30'd0, new_flag0, new_flag1}, 32'd3);
        repeat (4) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        e = q.pop_front();
        chk("done_rd_u", rd_data0, e.u);
        chk("done_rd_s", rd_data1, e.s);
        chk("done_flag_wins", {30'd0, new_flag0, new_flag1}, 32'd3);
        chk("done_idle", {30'd0, busy0, busy1}, 32'd0);
        do_read("c307");

        set_in(1'b0, 4'd0, 4'hC, 4'd0);
        run_conv("clamp");
        do_read("clamp");
        set_in(1'b0, 4'd0, 4'd0, 4'd0);
        run_conv("back0");
        do_read("back0");

        set_in(1'b0, 4'd0, 4'hC, 4'd0);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy0}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", {30'd0, busy0, busy1}, 32'd0);
        chk("arst_flag", {30'd0, new_flag0, new_flag1}, 32'd0);
        chk("arst_rd_u", rd_data0, 32'd0);
        chk("arst_rd_s", rd_data1, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_conv("restart");
        do_read("restart");

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/input_bcd2bin.md
Name: input_bcd2bin

Overview:
Downstream stage of the switch/button digit-entry block. It consumes the four entered digits (x1 = 0/1 thousands or sign, x2..x4 = BCD hundreds/tens/units) and converts them into a 32-bit binary word. The word is exposed to the CPU's memory-mapped input port with a busy/new-data handshake. Conversion is sequential: one multiply-by-10-and-add per cycle, started automatically whenever the digits change.

Parameters:
SIGNED_X1, 0, 0: x1 is the thousands digit (range 0..1999); 1: x1 is the sign (1 = negative, range -999..999)
DATA_W, 32, width of result and rd_data

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
x1  input  1  thousands digit or sign bit (per SIGNED_X1)
x2  input  4  BCD hundreds digit
x3  input  4  BCD tens digit
x4  input  4  BCD units digit
rd_en  input  1  CPU read strobe, single-cycle pulse
rd_data  output  DATA_W  registered read data
new_flag  output  1  1 = result updated since last read
busy  output  1  1 while the FSM is in CONV or DONE

Behaviour:
- Reset (async, active-high): state=IDLE; snapshot {x1,x2,x3,x4}=0; acc=0; idx=0; result=0; rd_data=0; new_flag=0; busy=0.
- Clamp: any x2..x4 digit > 9 is treated as 9 at snapshot time. x1 is used as-is.
- Digit order for accumulation: d0 = x1 (forced to 0 when SIGNED_X1=1), d1 = x2, d2 = x3, d3 = x4.
- IDLE: if live clamped inputs != snapshot, latch them into snapshot, set acc=0, idx=0, and go to CONV. Otherwise stay in IDLE.
- CONV: each cycle acc <= acc*10 + d[idx] and idx++. After the idx=3 step, go to DONE. This is exactly 4 cycles.
- DONE: result <= (SIGNED_X1 && snapshot.x1) ? -acc (two's complement, DATA_W bits) : acc. Set new_flag=1 and go to IDLE.
- Latency: the change is sampled at edge E in IDLE, and result/new_flag update at edge E+5. busy=1 from E+1 through E+5 inclusive, and returns to 0 after E+5.
- Input changes during CONV/DONE are ignored by the running conversion. They are detected on the first IDLE cycle afterwards and trigger a new conversion, with no pulse lost.
- Negative zero (SIGNED_X1=1, x1=1, x2..x4=0) gives result 0.
- Arithmetic: acc is DATA_W wide. The maximum magnitude is 1999, so no overflow is possible.
- Read: on rd_en, rd_data <= result (the value before any same-cycle DONE write) and new_flag <= 0. rd_data holds between reads.
- rd_en in the same cycle as DONE: the DONE write wins for new_flag, so new_flag stays 1. rd_data gets the old result.
- rd_en while busy is legal and returns the last completed result.
- Reset asserted mid-conversion: all state clears immediately and the conversion is abandoned. After release, nonzero inputs start a fresh conversion on the first clock edge.

Test Plan:
- Reset with all inputs 0 -> after release busy stays 0 for 20 cycles; result=0, new_flag=0, rd_data=0.
- SIGNED_X1=0, set x1=1,x2=2,x3=3,x4=4 -> busy high for 5 cycles; new_flag=1 at E+5. Then pulse rd_en -> next cycle rd_data=0x000004D2 and new_flag=0.
- SIGNED_X1=1, set x1=1,x2=1,x3=2,x4=5 -> rd_data=0xFFFFFF83 (-125). Then x1=1,x2=x3=x4=0 -> rd_data=0x00000000.
- Start from 0000, change x4=7, then change x2=3 two cycles later (mid-CONV) -> first DONE gives result 7. A second conversion auto-starts and result ends at 307; new_flag stays 1 throughout.
- Pulse rd_en in the exact DONE cycle of the 307 conversion (previous result 7) -> rd_data=7 and new_flag=1. A second rd_en -> rd_data=307 and new_flag=0.
- Set x3=4'hC -> treated as 9 (x1..x4=0,0,C,0 gives result 90). Assert rst asynchronously mid-CONV -> busy, new_flag, rd_data all 0 immediately with no clock; after release, a conversion restarts and produces 90.
